// File: rtl/pam_frame_syn_v2_if.sv
// Payload stream from the frame synchroniser to the PAM demodulator.
// The master drives the sample and its frame tags; the slave drives ready.
interface pam_frame_syn_v2_if #(
    parameter int AD_CVER_WIDTH = 12
);
    logic signed [AD_CVER_WIDTH-1:0] syn_demodu_data;
    logic                            syn_demodu_valid;
    logic                            syn_demodu_ready;
    logic                            syn_demodu_first;
    logic                            syn_demodu_last;

    modport master (
        output syn_demodu_data,
        output syn_demodu_valid,
        output syn_demodu_first,
        output syn_demodu_last,
        input  syn_demodu_ready
    );

    modport slave (
        input  syn_demodu_data,
        input  syn_demodu_valid,
        input  syn_demodu_first,
        input  syn_demodu_last,
        output syn_demodu_ready
    );
endinterface

// File: rtl/pam_frame_syn_v2.sv
// Preamble correlator, frame-timing tracker and payload FIFO between AD and PAM demodulator.
// Optional SYN_POLARITY_DETECT_EN adds locking on an inverted channel with payload negation.
module pam_frame_syn_v2 #(
    parameter int          AD_CVER_WIDTH      = 12,
    parameter int          LENGTH_M_SEQ       = 31,
    parameter logic [62:0] M_SEQ              = 63'h0000_0000_7C6E_A12C,
    parameter int          LENGTH_DATA        = 32,
    parameter int          WIDTH_RESULT       = 6,
    parameter int          MAX_MISS           = 2,
    parameter int          SYN_MEM_ADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            srst,
    input  logic signed [AD_CVER_WIDTH-1:0] ad_rec_data,
    input  logic                            ad_rec_valid,
    input  logic [WIDTH_RESULT-1:0]         cfg_threshold,
    pam_frame_syn_v2_if.master              dmd,
    output logic                            sync_locked,
    output logic                            sync_lost,
    output logic                            ovf_flag
);

    localparam int DEPTH  = 1 << SYN_MEM_ADDR_WIDTH;
    localparam int FW     = AD_CVER_WIDTH + 2;
    localparam int OCC_W  = SYN_MEM_ADDR_WIDTH + 1;
    localparam int CNT_W  = $clog2(LENGTH_DATA + LENGTH_M_SEQ + 1);
    localparam int MISS_W = 4;

    localparam logic [LENGTH_M_SEQ-1:0] M_PAT     = M_SEQ[LENGTH_M_SEQ-1:0];
    localparam logic [WIDTH_RESULT-1:0] LEN_W     = WIDTH_RESULT'(LENGTH_M_SEQ);
    localparam logic [CNT_W-1:0]        LAST_DATA = CNT_W'(LENGTH_DATA - 1);
    localparam logic [CNT_W-1:0]        LAST_CHIP = CNT_W'(LENGTH_M_SEQ - 1);
    localparam logic [MISS_W-1:0]       MISS_LIM  = MISS_W'(MAX_MISS - 1);
    localparam logic [OCC_W-1:0]        DEPTH_O   = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCK   = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    // Agreement count between the chip window and the preamble pattern.
    function automatic logic [WIDTH_RESULT-1:0] corr_count(input logic [LENGTH_M_SEQ-1:0] w);
        logic [LENGTH_M_SEQ-1:0] agree;
        logic [WIDTH_RESULT-1:0] n;
        agree = ~(w ^ M_PAT);
        n     = '0;
        for (int i = 0; i < LENGTH_M_SEQ; i++) begin
            n = n + WIDTH_RESULT'(agree[i]);
        end
        return n;
    endfunction

`ifdef SYN_POLARITY_DETECT_EN
    localparam logic signed [AD_CVER_WIDTH-1:0] S_MIN = {1'b1, {(AD_CVER_WIDTH-1){1'b0}}};
    localparam logic signed [AD_CVER_WIDTH-1:0] S_MAX = {1'b0, {(AD_CVER_WIDTH-1){1'b1}}};

    // Negation that folds the most negative code onto the largest positive one.
    function automatic logic signed [AD_CVER_WIDTH-1:0] neg_sat(
        input logic signed [AD_CVER_WIDTH-1:0] x
    );
        if (x == S_MIN) begin
            return S_MAX;
        end
        return -x;
    endfunction
`endif

    state_t                  state_q, state_d;
    logic [LENGTH_M_SEQ-1:0] win_q, win_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [MISS_W-1:0]       miss_q, miss_d;
    logic                    locked_q, locked_d;
    logic                    lost_q, lost_d;
    logic                    ovf_q, ovf_d;
`ifdef SYN_POLARITY_DETECT_EN
    logic                    inv_q, inv_d;
    logic                    hit_neg;
`endif

    logic                            chip_in;
    logic [LENGTH_M_SEQ-1:0]         win_cur;
    logic [WIDTH_RESULT-1:0]         corr;
    logic                            hit_pos;
    logic                            chk_hit;
    logic signed [AD_CVER_WIDTH-1:0] push_data;
    logic                            push_req;
    logic                            push_first;
    logic                            push_last;
    logic [FW-1:0]                   push_word;

    // Newest chip enters at the top so the oldest sits at bit 0, matching M_SEQ order.
    assign chip_in = ~ad_rec_data[AD_CVER_WIDTH-1];
    assign win_cur = {chip_in, win_q[LENGTH_M_SEQ-1:1]};
    assign corr    = corr_count(win_cur);
    assign hit_pos = (corr >= cfg_threshold);

`ifdef SYN_POLARITY_DETECT_EN
    assign hit_neg   = ((LEN_W - corr) >= cfg_threshold);
    assign chk_hit   = inv_q ? hit_neg : hit_pos;
    assign push_data = inv_q ? neg_sat(ad_rec_data) : ad_rec_data;
`else
    assign chk_hit   = hit_pos;
    assign push_data = ad_rec_data;
`endif

    assign push_word = {push_first, push_last, push_data};

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        miss_d     = miss_q;
        lost_d     = 1'b0;
        push_req   = 1'b0;
        push_first = 1'b0;
        push_last  = 1'b0;
`ifdef SYN_POLARITY_DETECT_EN
        inv_d      = (state_q == ST_SEARCH) ? 1'b0 : inv_q;
`endif
        if (ad_rec_valid) begin
            win_d = win_cur;
            case (state_q)
                ST_SEARCH: begin
                    if (hit_pos) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                    end
`ifdef SYN_POLARITY_DETECT_EN
                    else if (hit_neg) begin
                        state_d = ST_LOCK;
                        cnt_d   = '0;
                        inv_d   = 1'b1;
                    end
`endif
                end
                ST_LOCK: begin
                    push_req   = 1'b1;
                    push_first = (cnt_q == '0);
                    push_last  = (cnt_q == LAST_DATA);
                    if (cnt_q == LAST_DATA) begin
                        state_d = ST_CHECK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (cnt_q == LAST_CHIP) begin
                        cnt_d = '0;
                        if (chk_hit) begin
                            miss_d  = '0;
                            state_d = ST_LOCK;
                        end else if (miss_q == MISS_LIM) begin
                            miss_d  = '0;
                            lost_d  = 1'b1;
                            state_d = ST_SEARCH;
                        end else begin
                            // Flywheel: keep the expected timing through a missed preamble.
                            miss_d  = miss_q + MISS_W'(1);
                            state_d = ST_LOCK;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCK) || (state_d == ST_CHECK);
    end

    logic [FW-1:0]                 mem_q [DEPTH];
    logic [SYN_MEM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [SYN_MEM_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]              occ_q, occ_d;
    logic                          out_vld_q, out_vld_d;
    logic [FW-1:0]                 out_word_q, out_word_d;
    logic                          pop;
    logic                          full;
    logic                          push;
    logic                          mem_empty;
    logic                          mem_we;

    // Occupancy counts the output register too, so total storage equals DEPTH.
    always_comb begin
        pop        = out_vld_q && dmd.syn_demodu_ready;
        full       = (occ_q == DEPTH_O);
        push       = push_req && (!full || pop);
        ovf_d      = ovf_q | (push_req && full && !pop);
        mem_empty  = (wr_ptr_q == rd_ptr_q);
        out_vld_d  = out_vld_q;
        out_word_d = out_word_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_we     = 1'b0;
        if (!out_vld_q || pop) begin
            if (!mem_empty) begin
                out_word_d = mem_q[rd_ptr_q];
                out_vld_d  = 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
                if (push) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end else if (push) begin
                out_word_d = push_word;
                out_vld_d  = 1'b1;
            end else begin
                out_vld_d  = 1'b0;
            end
        end else if (push) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q    <= ST_SEARCH;
            win_q      <= '0;
            cnt_q      <= '0;
            miss_q     <= '0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            out_vld_q  <= 1'b0;
            out_word_q <= '0;
`ifdef SYN_POLARITY_DETECT_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            miss_q     <= miss_d;
            locked_q   <= locked_d;
            lost_q     <= lost_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            out_vld_q  <= out_vld_d;
            out_word_q <= out_word_d;
`ifdef SYN_POLARITY_DETECT_EN
            inv_q      <= inv_d;
`endif
        end
    end

    assign dmd.syn_demodu_data  = out_word_q[AD_CVER_WIDTH-1:0];
    assign dmd.syn_demodu_first = out_word_q[FW-1];
    assign dmd.syn_demodu_last  = out_word_q[FW-2];
    assign dmd.syn_demodu_valid = out_vld_q;
    assign sync_locked          = locked_q;
    assign sync_lost            = lost_q;
    assign ovf_flag             = ovf_q;

endmodule

// File: tb/tb_pam_frame_syn_v2.sv
// Directed bench for pam_frame_syn_v2 with a queue-based reference model checked every cycle.
module tb_pam_frame_syn_v2;
    localparam int          W     = 12;
    localparam int          L     = 31;
    localparam int          LD    = 32;
    localparam int          DEPTH = 32;
    localparam int          MAXM  = 2;
    localparam logic [62:0] MSEQ  = 63'h0000_0000_7C6E_A12C;

    logic                clk = 1'b0;
    logic                srst = 1'b1;
    logic signed [W-1:0] ad_data = '0;
    logic                ad_valid = 1'b0;
    logic [5:0]          thr = 6'd25;
    logic                sync_locked, sync_lost, ovf_flag;

    always #5 clk = ~clk;

    pam_frame_syn_v2_if #(.AD_CVER_WIDTH(W)) dmd_if ();

    pam_frame_syn_v2 #(
        .AD_CVER_WIDTH(W), .LENGTH_M_SEQ(L), .M_SEQ(MSEQ), .LENGTH_DATA(LD),
        .WIDTH_RESULT(6), .MAX_MISS(MAXM), .SYN_MEM_ADDR_WIDTH(5)
    ) dut (
        .clk(clk), .srst(srst), .ad_rec_data(ad_data), .ad_rec_valid(ad_valid),
        .cfg_threshold(thr), .dmd(dmd_if), .sync_locked(sync_locked),
        .sync_lost(sync_lost), .ovf_flag(ovf_flag)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: chip history, frame mode, and an ideal bounded FIFO.
    logic        hist[$];
    logic [13:0] m_fifo[$];
    logic [13:0] got[$];
    int          m_mode;   // 0 searching, 1 payload, 2 checking preamble
    int          m_idx, m_miss, m_corr, m_val;
    bit          m_inv, m_ovf, m_locked, m_lost, m_pos, m_neg, m_hit;

    function automatic int corr_of();
        int n = 0;
        for (int i = 0; i < L; i++) if (hist[i] == MSEQ[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (L) hist.push_back(1'b0);
        m_fifo.delete();
        m_mode = 0; m_idx = 0; m_miss = 0; m_corr = 0;
        m_inv = 0; m_ovf = 0; m_locked = 0; m_lost = 0;
    endtask

    always @(posedge clk) begin
        if (srst) begin
            model_reset();
        end else begin
            m_lost = 1'b0;
            if (m_fifo.size() != 0 && dmd_if.syn_demodu_ready) void'(m_fifo.pop_front());
            if (ad_valid) begin
                hist.push_back(!ad_data[W-1]);
                void'(hist.pop_front());
                m_corr = corr_of();
                m_pos  = (m_corr >= int'(thr));
                m_neg  = ((L - m_corr) >= int'(thr));
                if (m_mode == 0) begin
                    m_inv = 1'b0;
                    if (m_pos) begin m_mode = 1; m_idx = 0; end
`ifdef SYN_POLARITY_DETECT_EN
                    else if (m_neg) begin m_mode = 1; m_idx = 0; m_inv = 1'b1; end
`endif
                end else if (m_mode == 1) begin
                    m_val = int'(ad_data);
                    if (m_inv) m_val = (m_val == -2048) ? 2047 : -m_val;
                    if (m_fifo.size() < DEPTH)
                        m_fifo.push_back({m_idx == 0, m_idx == LD - 1, W'(m_val)});
                    else
                        m_ovf = 1'b1;
                    m_idx++;
                    if (m_idx == LD) begin m_mode = 2; m_idx = 0; end
                end else begin
                    m_idx++;
                    if (m_idx == L) begin
                        m_idx = 0;
                        m_hit = m_inv ? m_neg : m_pos;
                        if (m_hit) begin
                            m_miss = 0; m_mode = 1;
                        end else begin
                            m_miss++;
                            if (m_miss == MAXM) begin m_miss = 0; m_mode = 0; m_lost = 1'b1; end
                            else m_mode = 1;
                        end
                    end
                end
            end
            m_locked = (m_mode != 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", dmd_if.syn_demodu_valid, m_fifo.size() != 0);
            if (m_fifo.size() != 0)
                check("word", {dmd_if.syn_demodu_first, dmd_if.syn_demodu_last,
                               dmd_if.syn_demodu_data}, m_fifo[0]);
            check("locked", sync_locked, m_locked);
            check("lost", sync_lost, m_lost);
            check("ovf", ovf_flag, m_ovf);
            if (dmd_if.syn_demodu_valid && dmd_if.syn_demodu_ready)
                got.push_back({dmd_if.syn_demodu_first, dmd_if.syn_demodu_last, dmd_if.syn_demodu_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        ad_data  = W'(v);
        ad_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        ad_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_pre(input int nerr, input bit neg);
        for (int i = 0; i < L; i++) begin
            logic c;
            c = MSEQ[i] ^ (i < nerr);
            if (neg) c = ~c;
            send(c ? 100 : -100);
        end
        ad_valid = 1'b0;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        ad_valid = 1'b0;
        dmd_if.syn_demodu_ready = 1'b1;
        repeat (2) tick();
        srst = 1'b0;
        got.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        dmd_if.syn_demodu_ready = 1'b1;
        do_reset();
        chk_en = 1'b1;
        check("rst_valid", dmd_if.syn_demodu_valid, 0);
        check("rst_data", dmd_if.syn_demodu_data, 0);
        check("rst_locked", sync_locked, 0);
        check("rst_ovf", ovf_flag, 0);

        // Exact preamble and one frame of ramp payload.
        send_pre(0, 1'b0);
        check("t1_corr", m_corr, 31);
        check("t1_locked", sync_locked, 1);
        for (int i = 0; i < LD; i++) send(i);
        idle(3);
        check("t1_count", got.size(), 32);
        check("t1_first", got[0], 14'h2000);
        check("t1_last", got[31], 14'h101F);

        // Error tolerance around the threshold.
        do_reset();
        send_pre(5, 1'b0);
        check("t2_corr26", m_corr, 26);
        check("t2_lock26", sync_locked, 1);
        do_reset();
        send_pre(7, 1'b0);
        idle(3);
        check("t2_corr24", m_corr, 24);
        check("t2_nolock24", sync_locked, 0);
        check("t2_noout", got.size(), 0);

        // Two missed preambles drop sync.
        do_reset();
        send_pre(0, 1'b0);
        for (int i = 0; i < LD; i++) send(i);
        send_pre(31, 1'b0);
        check("t3_fly_locked", sync_locked, 1);
        for (int i = 0; i < LD; i++) send(100 + i);
        send_pre(31, 1'b0);
        check("t3_lost_pulse", sync_lost, 1);
        check("t3_unlocked", sync_locked, 0);
        tick();
        check("t3_lost_clear", sync_lost, 0);
        idle(3);
        check("t3_count", got.size(), 64);
        check("t3_fly_first", got[32], 14'h2064);

        // Backpressure and overflow.
        do_reset();
        send_pre(0, 1'b0);
        dmd_if.syn_demodu_ready = 1'b0;
        for (int i = 0; i < LD; i++) send(i);
        send_pre(0, 1'b0);
        check("t4_no_ovf_yet", ovf_flag, 0);
        for (int i = 32; i < 40; i++) send(i);
        idle(1);
        check("t4_ovf", ovf_flag, 1);
        check("t4_held", dmd_if.syn_demodu_valid, 1);
        got.delete();
        dmd_if.syn_demodu_ready = 1'b1;
        idle(40);
        check("t4_drained", got.size(), 32);
        check("t4_d0", got[0], 14'h2000);
        check("t4_d10", got[10], 14'h000A);
        check("t4_d31", got[31], 14'h101F);
        check("t4_ovf_sticky", ovf_flag, 1);

        // Reset in the middle of a payload, then a clean relock.
        do_reset();
        send_pre(0, 1'b0);
        for (int i = 0; i < 10; i++) send(i);
        srst = 1'b1;
        send(10);
        srst = 1'b0;
        ad_valid = 1'b0;
        check("t5_valid", dmd_if.syn_demodu_valid, 0);
        check("t5_locked", sync_locked, 0);
        got.delete();
        send_pre(0, 1'b0);
        check("t5_relock", sync_locked, 1);
        for (int i = 0; i < LD; i++) send(200 + i);
        idle(3);
        check("t5_count", got.size(), 32);
        check("t5_first", got[0], 14'h20C8);
        check("t5_last", got[31], 14'h10E7);

        // Inverted channel.
        do_reset();
        send_pre(0, 1'b1);
`ifdef SYN_POLARITY_DETECT_EN
        check("t6_inv_lock", sync_locked, 1);
        send(100);
        send(-2048);
        for (int i = 2; i < LD; i++) send(i);
        idle(3);
        check("t6_neg100", got[0], 14'h2F9C);
        check("t6_sat", got[1], 14'h07FF);
`else
        check("t6_no_inv_lock", sync_locked, 0);
        idle(3);
        check("t6_noout", got.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pam_frame_syn_v2.md
Name: pam_frame_syn_v2

Overview:
- Parametrised successor to the fixed-length receiver synchroniser; sits between the AD sample interface and the PAM demodulator.
- Correlates incoming samples against a configurable m-sequence preamble using a runtime threshold.
- Tracks frame timing across consecutive frames, declaring loss of sync after a programmable number of missed preambles.
- Buffers payload samples in a FIFO with valid/ready output, so the demodulator may apply backpressure.

Parameters:
AD_CVER_WIDTH, 12, sample width, two's complement
LENGTH_M_SEQ, 31, preamble length in chips (8..63)
M_SEQ, 63'h0000_0000_7C6E_A12C (bit0 = first chip), preamble pattern; bit=1 means positive chip
LENGTH_DATA, 32, payload samples per frame (1..4095)
WIDTH_RESULT, 6, correlation width; must hold LENGTH_M_SEQ
MAX_MISS, 2, consecutive missed preambles before sync is dropped (1..15)
SYN_MEM_ADDR_WIDTH, 5, FIFO depth = 2^SYN_MEM_ADDR_WIDTH

Ports:
clk  in  1  system clock
srst  in  1  synchronous reset, active-high
ad_rec_data  in  AD_CVER_WIDTH  AD sample
ad_rec_valid  in  1  sample strobe; no backpressure toward the AD
cfg_threshold  in  WIDTH_RESULT  lock threshold; sampled every cycle
syn_demodu_data  out  AD_CVER_WIDTH  payload sample
syn_demodu_valid  out  1  FIFO not empty
syn_demodu_ready  in  1  demodulator accepts the sample
syn_demodu_first  out  1  marks payload sample 0 of a frame
syn_demodu_last  out  1  marks payload sample LENGTH_DATA-1
sync_locked  out  1  high in the LOCK and CHECK states
sync_lost  out  1  one-cycle pulse when leaving CHECK for SEARCH
ovf_flag  out  1  sticky FIFO overflow indicator; cleared only by srst

Behaviour:
- Reset: all outputs 0, FIFO empty, state SEARCH, chip window cleared, miss count 0. srst mid-frame discards all buffered data on the same edge.
- Chip decision: chip = ~ad_rec_data[MSB], so sample >= 0 gives chip 1. The window shifts only on ad_rec_valid and holds the newest LENGTH_M_SEQ chips.
- Correlation: corr = number of positions where the window equals M_SEQ. It is evaluated on the window including the current sample. hit = (corr >= cfg_threshold).
- FSM:
  - SEARCH: on a valid sample with hit, go to LOCK. The next valid sample is payload 0.
  - LOCK: each valid sample is pushed into the FIFO with first/last tags. After LENGTH_DATA samples, go to CHECK and clear the chip counter.
  - CHECK: count LENGTH_M_SEQ valid samples, which are not pushed.
    - On the last chip with hit: miss count = 0, go to LOCK.
    - Without hit: increment miss count. If it reaches MAX_MISS, pulse sync_lost, set miss count to 0 and go to SEARCH. Otherwise go to LOCK anyway (flywheel).
  - A hit in LOCK or CHECK at any position other than the last CHECK chip is ignored.
- FIFO:
  - Width AD_CVER_WIDTH+2 (sample, first, last).
  - Pop happens when valid && ready.
  - Push into a full FIFO drops the sample and sets ovf_flag, unless a pop occurs on the same cycle; a simultaneous push and pop when full is legal.
  - Output is registered first-word-fall-through. Latency from the accepted sample to syn_demodu_valid is 1 cycle when the FIFO is empty.
- Counters wrap only through explicit FSM transitions; no free-running wrap.

Optional Feature:
SYN_POLARITY_DETECT_EN:
- Defined:
  - In SEARCH, also lock when (LENGTH_M_SEQ - corr) >= cfg_threshold, i.e. an inverted channel, and latch inv=1.
  - While inv=1, payload samples are negated before the push, with the most negative code saturating to the maximum positive code.
  - The CHECK test uses the same inverted comparison.
  - inv clears in SEARCH.
- Undefined: only positive correlation locks; no negation logic.

Test Plan:
- Exact preamble (corr=31, threshold 25), then payload 0..31 with ready=1 -> out 0..31; first on 0, last on 31; sync_locked=1 one cycle after the last chip.
- Preamble with 5 chip errors (corr=26) -> lock. Same preamble with 7 errors (corr=24) -> stays in SEARCH, no output.
- Lock, then two consecutive corrupted preambles, MAX_MISS=2 -> first miss keeps payload flowing; on the second, sync_lost pulses 1 cycle and sync_locked=0.
- ready=0 across 40 payload samples, depth 32 -> 32 stored, ovf_flag=1. Samples 32..39 lost. ready=1 drains 0..31 in order.
- srst asserted mid-payload (sample 10) -> next cycle valid=0, locked=0. A subsequent clean frame locks normally.
- With SYN_POLARITY_DETECT_EN: negated preamble and payload +100 -> lock; output payload -100 (two's complement); -2048 outputs +2047.
